postfix_sequencer: RTL and testbench

Upstream feeder for `STACK_BASED_ALU`. Accepts a stream of postfix-expression tokens over a valid/ready handshake and converts each into one ALU opcode/data pair per cycle. Tracks stack depth to catch malformed expressions and accumulates the ALU overflow flag. On the end token it pops the final value and presents it on a result handshake. Sits between the token source (host FIFO) and the ALU; ALU `output_data`/`overflow` loop back into this block.

---
 rtl/stack_alu_pkg.sv | 25 ++
 rtl/postfix_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_postfix_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_alu_pkg.sv
// Shared constants for the postfix sequencer and its STACK_BASED_ALU sibling:
// ALU opcodes, token kinds and the sequencer state encoding.
package stack_alu_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  localparam logic [1:0] TK_OPND = 2'b00;
  localparam logic [1:0] TK_ADD  = 2'b01;
  localparam logic [1:0] TK_MUL  = 2'b10;
  localparam logic [1:0] TK_END  = 2'b11;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_ACCEPT,
    ST_POP1,
    ST_POP2,
    ST_ERR,
    ST_DONE
  } state_e;

endpackage

// File: rtl/postfix_sequencer.sv
// Converts a postfix token stream into one ALU opcode/data pair per cycle,
// tracks stack depth for malformed expressions and returns the final value.
module postfix_sequencer
  import stack_alu_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                tok_valid,
  output logic                tok_ready,
  input  logic [1:0]          tok_kind,
  input  logic signed [N-1:0] tok_data,
  output logic [2:0]          alu_opcode,
  output logic signed [N-1:0] alu_data,
  input  logic signed [N-1:0] alu_result,
  input  logic                alu_overflow,
  output logic                res_valid,
  input  logic                res_ready,
  output logic signed [N-1:0] res_data,
  output logic                res_overflow,
  output logic                res_error
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
  localparam logic [CW-1:0] INIT_LAST = CW'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [DW-1:0]       depth_q, depth_d;
  logic [CW-1:0]       init_cnt_q, init_cnt_d;
  logic                end_seen_q, end_seen_d;
  logic                sticky_q, sticky_d;
  logic [2:0]          op_q, op_d;
  logic signed [N-1:0] data_q, data_d;
  logic signed [N-1:0] res_data_q, res_data_d;
  logic                res_ovf_q, res_ovf_d;
  logic                res_err_q, res_err_d;
  logic                arith_issue;
  logic                arith_vld_p0, arith_vld_p1;
  logic                tok_hs, res_hs, tok_end;

  assign tok_hs  = tok_valid & tok_ready;
  assign res_hs  = res_valid & res_ready;
  assign tok_end = tok_hs && (tok_kind == TK_END);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_INIT;
      depth_q    <= '0;
      init_cnt_q <= '0;
      end_seen_q <= 1'b0;
      sticky_q   <= 1'b0;
      op_q       <= OP_NOP;
      data_q     <= '0;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      depth_q    <= depth_d;
      init_cnt_q <= init_cnt_d;
      end_seen_q <= end_seen_d;
      sticky_q   <= sticky_d;
      op_q       <= op_d;
      data_q     <= data_d;
      res_data_q <= res_data_d;
      res_ovf_q  <= res_ovf_d;
      res_err_q  <= res_err_d;
    end
  end

  // Issue -> ALU execute (p0) -> overflow valid for sampling (p1)
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      arith_vld_p0 <= 1'b0;
      arith_vld_p1 <= 1'b0;
    end else begin
      arith_vld_p0 <= arith_issue;
      arith_vld_p1 <= arith_vld_p0;
    end
  end

  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    init_cnt_d  = init_cnt_q;
    end_seen_d  = end_seen_q;
    op_d        = OP_NOP;
    data_d      = '0;
    arith_issue = 1'b0;
    res_data_d  = res_data_q;
    res_ovf_d   = res_ovf_q;
    res_err_d   = res_err_q;
    sticky_d    = sticky_q | (arith_vld_p1 & alu_overflow);
    unique case (state_q)
      ST_INIT: begin
        op_d       = OP_POP;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == INIT_LAST) begin
          init_cnt_d = '0;
          state_d    = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (tok_hs) begin
          unique case (tok_kind)
            TK_OPND: begin
              if (depth_q == DEPTH_MAX) begin
                state_d = ST_ERR;
              end else begin
                op_d    = OP_PUSH;
                data_d  = tok_data;
                depth_d = depth_q + 1'b1;
              end
            end
            TK_ADD, TK_MUL: begin
              if (depth_q < DW'(2)) begin
                state_d = ST_ERR;
              end else begin
                op_d        = (tok_kind == TK_ADD) ? OP_ADD : OP_MUL;
                arith_issue = 1'b1;
                depth_d     = depth_q - 1'b1;
              end
            end
            TK_END: begin
              if (depth_q != DW'(1)) begin
                state_d    = ST_ERR;
                end_seen_d = 1'b1;
              end else begin
                op_d    = OP_POP;
                depth_d = '0;
                state_d = ST_POP1;
              end
            end
            default: state_d = ST_ERR;
          endcase
        end
      end
      ST_POP1: state_d = ST_POP2;
      ST_POP2: begin
        res_data_d = alu_result;
        res_ovf_d  = sticky_d;
        res_err_d  = 1'b0;
        state_d    = ST_DONE;
      end
      ST_ERR: begin
        // Tokens are swallowed here; only an end token matters, and it may
        // arrive while the ALU stack is still being drained.
        if (tok_end) end_seen_d = 1'b1;
        if (depth_q != '0) begin
          op_d    = OP_POP;
          depth_d = depth_q - 1'b1;
        end else if (end_seen_q || tok_end) begin
          end_seen_d = 1'b0;
          res_data_d = '0;
          res_ovf_d  = sticky_d;
          res_err_d  = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        if (res_hs) begin
          res_data_d = '0;
          res_ovf_d  = 1'b0;
          res_err_d  = 1'b0;
          sticky_d   = 1'b0;
          state_d    = ST_ACCEPT;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    tok_ready = (state_q == ST_ACCEPT) || (state_q == ST_ERR);
    res_valid = (state_q == ST_DONE);
  end

  assign alu_opcode   = op_q;
  assign alu_data     = data_q;
  assign res_data     = res_data_q;
  assign res_overflow = res_ovf_q;
  assign res_error    = res_err_q;

endmodule

// File: tb/tb_postfix_sequencer.sv
// Directed bench for postfix_sequencer with a behavioural stack ALU closing
// the opcode/result loop.
module tb_postfix_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       tok_valid = 1'b0;
  logic       tok_ready;
  logic [1:0] tok_kind = 2'b00;
  logic [3:0] tok_data = 4'h0;
  logic [2:0] alu_opcode;
  logic [3:0] alu_data;
  logic [3:0] alu_result;
  logic       alu_overflow;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_data;
  logic       res_overflow;
  logic       res_error;

  int tests = 0;
  int fails = 0;

  postfix_sequencer #(.N(4), .DEPTH(8)) dut (
    .CLK(CLK), .RST(RST),
    .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_kind(tok_kind), .tok_data(tok_data),
    .alu_opcode(alu_opcode), .alu_data(alu_data),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_overflow(res_overflow), .res_error(res_error)
  );

  always #5 CLK = ~CLK;

  // Behavioural 8-entry stack ALU, deliberately not reset.
  logic signed [3:0] stk [8];
  int                sp = 0;
  logic [3:0]        alu_out = 4'h0;
  logic              alu_ovf = 1'b0;
  assign alu_result   = alu_out;
  assign alu_overflow = alu_ovf;

  always @(posedge CLK) begin
    int a, b, r;
    alu_ovf <= 1'b0;
    case (alu_opcode)
      3'b110: if (sp < 8) begin stk[sp] <= alu_data; sp <= sp + 1; end
      3'b111: if (sp > 0) begin alu_out <= stk[sp-1]; sp <= sp - 1; end
      3'b100, 3'b101: if (sp > 1) begin
        a = stk[sp-2];
        b = stk[sp-1];
        r = (alu_opcode == 3'b100) ? a + b : a * b;
        stk[sp-2] <= r[3:0];
        sp        <= sp - 1;
        alu_ovf   <= (r > 7) || (r < -8);
      end
      default: ;
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_tok(input logic [1:0] k, input logic [3:0] d);
    int n = 0;
    tok_valid = 1'b1;
    tok_kind  = k;
    tok_data  = d;
    while (!tok_ready && n < 50) begin @(negedge CLK); n++; end
    tests++;
    if (tok_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_tok: tok_ready=%b required 1 within 50 cycles", tok_ready);
    end
    @(negedge CLK);
    tok_valid = 1'b0;
  endtask

  task automatic wait_res(output int cyc);
    cyc = 0;
    while (!res_valid && cyc < 30) begin @(negedge CLK); cyc++; end
  endtask

  task automatic take_res;
    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0;
  endtask

  task automatic test_reset;
    int n = 0;
    @(negedge CLK);
    @(negedge CLK);
    tests++; if (alu_opcode !== 3'b000) begin fails++; $display("FAIL rst_opcode: got %b want 000", alu_opcode); end
    tests++; if (alu_data !== 4'h0) begin fails++; $display("FAIL rst_data: got %h want 0", alu_data); end
    tests++; if (tok_ready !== 1'b0) begin fails++; $display("FAIL rst_tok_ready: got %b want 0", tok_ready); end
    tests++; if (res_valid !== 1'b0 || res_data !== 4'h0 || res_overflow !== 1'b0 || res_error !== 1'b0) begin
      fails++; $display("FAIL rst_res: got v=%b d=%h o=%b e=%b want all 0", res_valid, res_data, res_overflow, res_error);
    end
    tests++; if (dut.depth_q !== 4'd0) begin fails++; $display("FAIL rst_depth: got %0d want 0", dut.depth_q); end
    RST = 1'b0;
    while (!tok_ready && n < 20) begin @(negedge CLK); n++; end
    tests++; if (n !== 8) begin fails++; $display("FAIL rst_init_len: got %0d cycles want 8", n); end
  endtask

  task automatic test_add_basic;
    int cyc;
    send_tok(2'b00, 4'd3);
    tests++; if (alu_opcode !== 3'b110 || alu_data !== 4'd3) begin fails++; $display("FAIL add_op0: got %b/%h want 110/3", alu_opcode, alu_data); end
    send_tok(2'b00, 4'd4);
    tests++; if (alu_opcode !== 3'b110 || alu_data !== 4'd4) begin fails++; $display("FAIL add_op1: got %b/%h want 110/4", alu_opcode, alu_data); end
    send_tok(2'b01, 4'd0);
    tests++; if (alu_opcode !== 3'b100) begin fails++; $display("FAIL add_op2: got %b want 100", alu_opcode); end
    send_tok(2'b11, 4'd0);
    tests++; if (alu_opcode !== 3'b111) begin fails++; $display("FAIL add_op3: got %b want 111", alu_opcode); end
    wait_res(cyc);
    tests++; if (cyc !== 2) begin fails++; $display("FAIL add_latency: got %0d want 2", cyc); end
    tests++; if (res_valid !== 1'b1 || res_data !== 4'd7 || res_overflow !== 1'b0 || res_error !== 1'b0) begin
      fails++; $display("FAIL add_result: got v=%b d=%h o=%b e=%b want 1/7/0/0", res_valid, res_data, res_overflow, res_error);
    end
    take_res;
    tests++; if (res_valid !== 1'b0 || res_data !== 4'h0) begin fails++; $display("FAIL add_clear: got v=%b d=%h want 0/0", res_valid, res_data); end
  endtask

  task automatic test_overflow;
    int cyc;
    send_tok(2'b00, 4'd7);
    send_tok(2'b00, 4'd7);
    send_tok(2'b01, 4'd0);
    send_tok(2'b11, 4'd0);
    wait_res(cyc);
    tests++; if (res_valid !== 1'b1 || res_data !== 4'b1110 || res_overflow !== 1'b1 || res_error !== 1'b0) begin
      fails++; $display("FAIL ovf_result: got v=%b d=%b o=%b e=%b want 1/1110/1/0", res_valid, res_data, res_overflow, res_error);
    end
    take_res;
    send_tok(2'b00, 4'd1);
    send_tok(2'b11, 4'd0);
    wait_res(cyc);
    tests++; if (res_valid !== 1'b1 || res_data !== 4'd1 || res_overflow !== 1'b0) begin
      fails++; $display("FAIL ovf_sticky_clear: got v=%b d=%h o=%b want 1/1/0", res_valid, res_data, res_overflow);
    end
    take_res;
  endtask

  task automatic test_hold_done;
    int cyc;
    send_tok(2'b00, 4'd2);
    send_tok(2'b00, 4'd3);
    send_tok(2'b10, 4'd0);
    tests++; if (alu_opcode !== 3'b101) begin fails++; $display("FAIL hold_mul_op: got %b want 101", alu_opcode); end
    send_tok(2'b00, 4'd1);
    send_tok(2'b01, 4'd0);
    send_tok(2'b11, 4'd0);
    wait_res(cyc);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (res_valid !== 1'b1 || res_data !== 4'd7 || tok_ready !== 1'b0 || res_error !== 1'b0) begin
        fails++; $display("FAIL hold_cycle%0d: got v=%b d=%h rdy=%b e=%b want 1/7/0/0", i, res_valid, res_data, tok_ready, res_error);
      end
      @(negedge CLK);
    end
    take_res;
  endtask

  task automatic test_underflow_err;
    int cyc;
    bit saw_push = 1'b0;
    send_tok(2'b01, 4'd0);
    if (alu_opcode == 3'b110) saw_push = 1'b1;
    send_tok(2'b00, 4'd5);
    if (alu_opcode == 3'b110) saw_push = 1'b1;
    send_tok(2'b11, 4'd0);
    if (alu_opcode == 3'b110) saw_push = 1'b1;
    wait_res(cyc);
    tests++; if (saw_push !== 1'b0) begin fails++; $display("FAIL uflow_no_push: got push=%b want 0", saw_push); end
    tests++; if (res_valid !== 1'b1 || res_error !== 1'b1 || res_data !== 4'h0) begin
      fails++; $display("FAIL uflow_result: got v=%b e=%b d=%h want 1/1/0", res_valid, res_error, res_data);
    end
    take_res;
    tests++; if (res_error !== 1'b0 || tok_ready !== 1'b1) begin fails++; $display("FAIL uflow_clear: got e=%b rdy=%b want 0/1", res_error, tok_ready); end
  endtask

  task automatic test_overflow_depth;
    int pops = 0;
    for (int i = 0; i < 9; i++) send_tok(2'b00, 4'(i));
    tests++; if (alu_opcode !== 3'b000) begin fails++; $display("FAIL depth_9th_op: got %b want 000", alu_opcode); end
    tok_valid = 1'b1;
    tok_kind  = 2'b11;
    for (int j = 0; j < 8; j++) begin
      @(negedge CLK);
      tok_valid = 1'b0;
      if (alu_opcode == 3'b111) pops++;
    end
    tests++; if (pops !== 8) begin fails++; $display("FAIL depth_drain: got %0d pops want 8", pops); end
    @(negedge CLK);
    tests++; if (alu_opcode !== 3'b000) begin fails++; $display("FAIL depth_drain_end: got %b want 000", alu_opcode); end
    tests++; if (res_valid !== 1'b1 || res_error !== 1'b1 || res_data !== 4'h0) begin
      fails++; $display("FAIL depth_result: got v=%b e=%b d=%h want 1/1/0", res_valid, res_error, res_data);
    end
    tests++; if (dut.depth_q !== 4'd0) begin fails++; $display("FAIL depth_zero: got %0d want 0", dut.depth_q); end
    take_res;
  endtask

  task automatic test_mid_reset;
    int cyc;
    send_tok(2'b00, 4'd1);
    send_tok(2'b00, 4'd2);
    send_tok(2'b00, 4'd3);
    RST = 1'b1;
    #1;
    tests++; if (alu_opcode !== 3'b000 || alu_data !== 4'h0 || tok_ready !== 1'b0 || res_valid !== 1'b0) begin
      fails++; $display("FAIL mrst_async: got op=%b d=%h rdy=%b v=%b want 000/0/0/0", alu_opcode, alu_data, tok_ready, res_valid);
    end
    tests++; if (dut.depth_q !== 4'd0) begin fails++; $display("FAIL mrst_depth: got %0d want 0", dut.depth_q); end
    @(negedge CLK);
    RST = 1'b0;
    tests++; if (tok_ready !== 1'b0 || alu_opcode !== 3'b000) begin fails++; $display("FAIL mrst_init0: got rdy=%b op=%b want 0/000", tok_ready, alu_opcode); end
    for (int j = 1; j <= 8; j++) begin
      @(negedge CLK);
      tests++;
      if (alu_opcode !== 3'b111 || tok_ready !== (j == 8)) begin
        fails++; $display("FAIL mrst_init%0d: got op=%b rdy=%b want 111/%b", j, alu_opcode, tok_ready, (j == 8));
      end
    end
    send_tok(2'b00, 4'd3);
    send_tok(2'b11, 4'd0);
    wait_res(cyc);
    tests++; if (res_valid !== 1'b1 || res_data !== 4'd3 || res_error !== 1'b0 || res_overflow !== 1'b0) begin
      fails++; $display("FAIL mrst_result: got v=%b d=%h e=%b o=%b want 1/3/0/0", res_valid, res_data, res_error, res_overflow);
    end
    take_res;
  endtask

  initial begin
    test_reset;
    test_add_basic;
    test_overflow;
    test_hold_done;
    test_underflow_err;
    test_overflow_depth;
    test_mid_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
